// File: rtl/shift_pkg.sv
// Shared definitions for the shifter and its users.
//   DIR_LEFT / DIR_RIGHT : encodings of the is_left_shift control.
//   shift_cw(size)       : width of a counter that indexes bits 0..size-1.
package shift_pkg;

   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_RIGHT = 1'b0;

   function automatic int shift_cw(input int size);
      return ($clog2(size) > 0) ? $clog2(size) : 1;
   endfunction

endpackage

// File: rtl/shifter.sv
// Combinational one-position shifter used along the serial datapath.
// Ports:
//   is_left_shift : 1 = shift toward MSB (shift_in enters at bit 0),
//                   0 = shift toward LSB (shift_in enters at bit SIZE-1)
//   shift_in      : bit entering the vacated position
//   data          : word to shift
//   data_out      : shifted word
//   shift_out     : bit pushed out of the word
module shifter
   import shift_pkg::*;
#(
   parameter int SIZE = 8
) (
   input  logic            is_left_shift,
   input  logic            shift_in,
   input  logic [SIZE-1:0] data,
   output logic [SIZE-1:0] data_out,
   output logic            shift_out
);

   generate
      if (SIZE == 1) begin : g_single
         assign data_out  = shift_in;
         assign shift_out = data[0];
      end else begin : g_multi
         always_comb begin
            data_out  = '0;
            shift_out = 1'b0;
            if (is_left_shift == DIR_LEFT) begin
               data_out  = {data[SIZE-2:0], shift_in};
               shift_out = data[SIZE-1];
            end else begin
               data_out  = {shift_in, data[SIZE-1:1]};
               shift_out = data[0];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel collector. Accepts one bit per cycle and assembles
// SIZE-bit words, MSB-first (left) or LSB-first (right), with the direction
// chosen on the first bit of each word. Completed words sit in a one-entry
// buffer behind a valid/ready handshake.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous abort of the partial word (output buffer untouched)
//   is_left_shift       : direction for a word being started
//   bit_in, bit_valid   : serial input, bit_ready is the accept handshake
//   data_out, word_left : completed word and its direction
//   word_valid          : data_out holds an unconsumed word; word_ready consumes it
//   bit_count           : bits collected so far in the current word
module shift_deserializer
   import shift_pkg::*;
#(
   parameter int SIZE = 8,
   parameter int CW   = shift_cw(SIZE)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   input  logic            is_left_shift,
   input  logic            bit_in,
   input  logic            bit_valid,
   output logic            bit_ready,
   output logic [SIZE-1:0] data_out,
   output logic            word_left,
   output logic            word_valid,
   input  logic            word_ready,
   output logic [CW-1:0]   bit_count
);

   logic [SIZE-1:0] acc;
   logic [SIZE-1:0] acc_next;
   logic            dir_q;
   logic            dir_sel;
   logic            last_bit;
   logic            accept;
   logic            load;
   logic            unused_shift_out;

   // The first bit of a word takes its direction straight from the input,
   // later bits use the latched copy.
   assign dir_sel  = (bit_count == '0) ? is_left_shift : dir_q;
   assign last_bit = (bit_count == CW'(SIZE - 1));

   // Only the final bit of a word needs a free buffer slot; a consumer taking
   // the word in the same cycle frees it (combinational word_ready path).
   assign bit_ready = rst_n && (!last_bit || !word_valid || word_ready);
   assign accept    = bit_valid && bit_ready && !clear;
   assign load      = accept && last_bit;

   shifter #(
      .SIZE (SIZE)
   ) u_shifter (
      .is_left_shift (dir_sel),
      .shift_in      (bit_in),
      .data          (acc),
      .data_out      (acc_next),
      .shift_out     (unused_shift_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         bit_count  <= '0;
         dir_q      <= DIR_RIGHT;
         data_out   <= '0;
         word_left  <= 1'b0;
         word_valid <= 1'b0;
      end else begin
         if (clear) begin
            acc       <= '0;
            bit_count <= '0;
         end else if (accept) begin
            if (bit_count == '0) begin
               dir_q <= is_left_shift;
            end
            if (last_bit) begin
               acc       <= '0;
               bit_count <= '0;
            end else begin
               acc       <= acc_next;
               bit_count <= bit_count + CW'(1);
            end
         end

         if (load) begin
            data_out   <= acc_next;
            word_left  <= dir_sel;
            word_valid <= 1'b1;
         end else if (word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

   localparam int SIZE = 8;
   localparam int CW   = 3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clear;
   logic            is_left_shift;
   logic            bit_in;
   logic            bit_valid;
   logic            bit_ready;
   logic [SIZE-1:0] data_out;
   logic            word_left;
   logic            word_valid;
   logic            word_ready;
   logic [CW-1:0]   bit_count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct packed {
      logic [SIZE-1:0] data;
      logic            left;
   } word_t;

   word_t exp_q[$];

   shift_deserializer #(.SIZE(SIZE)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (clear),
      .is_left_shift (is_left_shift),
      .bit_in        (bit_in),
      .bit_valid     (bit_valid),
      .bit_ready     (bit_ready),
      .data_out      (data_out),
      .word_left     (word_left),
      .word_valid    (word_valid),
      .word_ready    (word_ready),
      .bit_count     (bit_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every transfer (word_valid && word_ready before an edge) pops one expected word.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_word: got %0h left %0b, scoreboard empty", data_out, word_left);
         end else begin
            word_t e;
            e = exp_q.pop_front();
            check("word_data", 32'(data_out), 32'(e.data));
            check("word_left", 32'(word_left), 32'(e.left));
         end
      end
   end

   // Entered at posedge+1; returns at posedge+1 after the bit is accepted.
   task automatic send_bit(input logic b, input logic dir);
      int n;
      bit_in        = b;
      is_left_shift = dir;
      bit_valid     = 1'b1;
      n = 0;
      @(negedge clk);
      while (bit_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("bit_accept_timeout", 32'(bit_ready), 32'd1);
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
   endtask

   task automatic send_word(input logic [SIZE-1:0] w, input logic left, input int nbits,
                            input int flip_at);
      for (int i = 0; i < nbits; i++) begin
         logic b, d;
         b = left ? w[SIZE-1-i] : w[i];
         d = (flip_at >= 0 && i >= flip_at) ? !left : left;
         send_bit(b, d);
      end
   endtask

   initial begin
      rst_n         = 1'b0;
      clear         = 1'b0;
      is_left_shift = 1'b0;
      bit_in        = 1'b0;
      bit_valid     = 1'b0;
      word_ready    = 1'b1;
      #12;
      check("rst_bit_ready", 32'(bit_ready), 32'd0);
      check("rst_word_valid", 32'(word_valid), 32'd0);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_bit_count", 32'(bit_count), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // left word, MSB-first
      exp_q.push_back('{data: 8'hB2, left: 1'b1});
      send_word(8'hB2, 1'b1, 8, -1);
      // right word, LSB-first, same bit sequence 1,0,1,1,0,0,1,0
      exp_q.push_back('{data: 8'h4D, left: 1'b0});
      send_word(8'h4D, 1'b0, 8, -1);
      // direction toggled after bit 3 is ignored
      exp_q.push_back('{data: 8'hB2, left: 1'b1});
      send_word(8'hB2, 1'b1, 8, 3);
      repeat (2) @(posedge clk);
      #1;
      check("no_stray_word", 32'(word_valid), 32'd0);

      // backpressure
      word_ready = 1'b0;
      exp_q.push_back('{data: 8'hB2, left: 1'b1});
      exp_q.push_back('{data: 8'h0F, left: 1'b1});
      send_word(8'hB2, 1'b1, 8, -1);
      send_word(8'h0F, 1'b1, 7, -1);
      check("bp_bit_count", 32'(bit_count), 32'd7);
      bit_in        = 1'b1;
      is_left_shift = 1'b1;
      bit_valid     = 1'b1;
      @(negedge clk);
      check("bp_bit_ready_low", 32'(bit_ready), 32'd0);
      check("bp_hold_data", 32'(data_out), 32'hB2);
      check("bp_hold_valid", 32'(word_valid), 32'd1);
      @(posedge clk);
      #1;
      check("bp_count_held", 32'(bit_count), 32'd7);
      word_ready = 1'b1;
      @(negedge clk);
      check("bp_bit_ready_high", 32'(bit_ready), 32'd1);
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      check("bp_new_data", 32'(data_out), 32'h0F);
      check("bp_new_valid", 32'(word_valid), 32'd1);
      check("bp_count_wrap", 32'(bit_count), 32'd0);
      @(posedge clk);
      #1;

      // clear drops the partial word and the coincident bit
      send_word(8'hFF, 1'b1, 3, -1);
      check("clr_pre_count", 32'(bit_count), 32'd3);
      clear     = 1'b1;
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(posedge clk);
      #1;
      clear     = 1'b0;
      bit_valid = 1'b0;
      check("clr_bit_count", 32'(bit_count), 32'd0);
      exp_q.push_back('{data: 8'hA5, left: 1'b1});
      send_word(8'hA5, 1'b1, 8, -1);
      @(posedge clk);
      #1;

      // async reset with a full buffer and a partial word
      word_ready = 1'b0;
      send_word(8'h5A, 1'b1, 8, -1);
      send_word(8'h77, 1'b0, 5, -1);
      check("ar_pre_valid", 32'(word_valid), 32'd1);
      check("ar_pre_count", 32'(bit_count), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_word_valid", 32'(word_valid), 32'd0);
      check("ar_data_out", 32'(data_out), 32'd0);
      check("ar_bit_count", 32'(bit_count), 32'd0);
      check("ar_bit_ready", 32'(bit_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n      = 1'b1;
      word_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back('{data: 8'h3C, left: 1'b0});
      send_word(8'h3C, 1'b0, 8, -1);
      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
